// File: rtl/mm_bypass_arbiter.sv
// Round-robin arbiter sharing one main-memory bypass port among NUM_REQ L1
// bypass requesters; one transaction in flight, with a sticky response watchdog.
module mm_bypass_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int ADDRESS_WIDTH  = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int MSG_BITS       = 3,
  parameter logic [MSG_BITS-1:0] NO_REQ   = 3'd0,
  parameter logic [MSG_BITS-1:0] R_REQ    = 3'd1,
  parameter logic [MSG_BITS-1:0] WB_REQ   = 3'd2,
  parameter logic [MSG_BITS-1:0] MEM_RESP = 3'd4,
  parameter logic [MSG_BITS-1:0] MEM_ACK  = 3'd5,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic [NUM_REQ*MSG_BITS-1:0]        req_msg,
  input  logic [NUM_REQ*ADDRESS_WIDTH-1:0]   req_address,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]      req_data,
  output logic [NUM_REQ*MSG_BITS-1:0]        resp_msg,
  output logic [NUM_REQ*ADDRESS_WIDTH-1:0]   resp_address,
  output logic [NUM_REQ*DATA_WIDTH-1:0]      resp_data,
  output logic [MSG_BITS-1:0]                arb2mm_msg,
  output logic [ADDRESS_WIDTH-1:0]           arb2mm_address,
  output logic [DATA_WIDTH-1:0]              arb2mm_data,
  input  logic [MSG_BITS-1:0]                mm2arb_msg,
  input  logic [ADDRESS_WIDTH-1:0]           mm2arb_address,
  input  logic [DATA_WIDTH-1:0]              mm2arb_data,
  output logic [NUM_REQ-1:0]                 grant,
  output logic                               busy,
  output logic                               timeout_err
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t                    state_reg, state_next;
  logic [PW-1:0]             rr_ptr_reg;
  logic [PW-1:0]             owner_reg;
  logic [PW-1:0]             win_idx;
  logic                      win_found;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        grant_reg;
  logic [MSG_BITS-1:0]       out_msg_reg;
  logic [MSG_BITS-1:0]       exp_resp_reg;
  logic [ADDRESS_WIDTH-1:0]  out_addr_reg;
  logic [DATA_WIDTH-1:0]     out_data_reg;
  logic [DATA_WIDTH-1:0]     rd_data_reg;
  logic [CW-1:0]             wd_cnt_reg;
  logic                      timeout_reg;
  logic [MSG_BITS-1:0]       owner_msg;
  logic [MSG_BITS-1:0]       win_msg;
  logic                      resp_match;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_valid[gi] = (req_msg[gi*MSG_BITS +: MSG_BITS] == R_REQ) ||
                           (req_msg[gi*MSG_BITS +: MSG_BITS] == WB_REQ);

    // Only the owner slice carries a response, and only while in RESP.
    assign resp_msg[gi*MSG_BITS +: MSG_BITS] =
      (state_reg == RESP && grant_reg[gi]) ? exp_resp_reg : NO_REQ;
    assign resp_address[gi*ADDRESS_WIDTH +: ADDRESS_WIDTH] =
      (state_reg == RESP && grant_reg[gi]) ? out_addr_reg : '0;
    assign resp_data[gi*DATA_WIDTH +: DATA_WIDTH] =
      (state_reg == RESP && grant_reg[gi]) ? rd_data_reg : '0;
  end

  // First valid requester at or after rr_ptr, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!win_found && req_valid[(int'(rr_ptr_reg) + k) % NUM_REQ]) begin
        win_found = 1'b1;
        win_idx   = PW'((int'(rr_ptr_reg) + k) % NUM_REQ);
      end
    end
  end

  assign win_msg    = req_msg[int'(win_idx)*MSG_BITS +: MSG_BITS];
  assign owner_msg  = req_msg[int'(owner_reg)*MSG_BITS +: MSG_BITS];
  assign resp_match = (mm2arb_msg == exp_resp_reg) && (mm2arb_address == out_addr_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (win_found)            state_next = ISSUE;
      ISSUE:   if (resp_match)           state_next = RESP;
      RESP:    if (owner_msg == NO_REQ)  state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      rr_ptr_reg   <= '0;
      owner_reg    <= '0;
      grant_reg    <= '0;
      out_msg_reg  <= NO_REQ;
      exp_resp_reg <= NO_REQ;
      out_addr_reg <= '0;
      out_data_reg <= '0;
      rd_data_reg  <= '0;
      wd_cnt_reg   <= '0;
      timeout_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: begin
          if (win_found) begin
            owner_reg    <= win_idx;
            grant_reg    <= NUM_REQ'(1) << win_idx;
            out_msg_reg  <= win_msg;
            out_addr_reg <= req_address[int'(win_idx)*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            out_data_reg <= req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
            exp_resp_reg <= (win_msg == R_REQ) ? MEM_RESP : MEM_ACK;
          end
        end
        ISSUE: begin
          if (resp_match) begin
            out_msg_reg <= NO_REQ;
            rd_data_reg <= (exp_resp_reg == MEM_RESP) ? mm2arb_data : '0;
          end
        end
        RESP: begin
          if (owner_msg == NO_REQ) begin
            grant_reg  <= '0;
            rr_ptr_reg <= (owner_reg == PW'(NUM_REQ - 1)) ? '0 : owner_reg + PW'(1);
          end
        end
        default: ;
      endcase

      // Watchdog counts completed ISSUE cycles and saturates at the limit.
      if (state_reg == ISSUE && !resp_match) begin
        if (wd_cnt_reg != WD_LIMIT) wd_cnt_reg <= wd_cnt_reg + CW'(1);
      end else begin
        wd_cnt_reg <= '0;
      end
      if (TIMEOUT_CYCLES != 0 && state_reg == ISSUE && (wd_cnt_reg + CW'(1)) == WD_LIMIT)
        timeout_reg <= 1'b1;
    end
  end

  assign arb2mm_msg     = out_msg_reg;
  assign arb2mm_address = out_addr_reg;
  assign arb2mm_data    = out_data_reg;
  assign grant          = grant_reg;
  assign busy           = (state_reg != IDLE);
  assign timeout_err    = timeout_reg;

endmodule

// File: tb/tb_mm_bypass_arbiter.sv
// Self-checking bench for mm_bypass_arbiter: directed scenarios plus randomized
// rounds checked against a transaction-level round-robin model.
module tb_mm_bypass_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int MB = 3;
  localparam logic [2:0] NO_REQ   = 3'd0;
  localparam logic [2:0] R_REQ    = 3'd1;
  localparam logic [2:0] WB_REQ   = 3'd2;
  localparam logic [2:0] MEM_RESP = 3'd4;
  localparam logic [2:0] MEM_ACK  = 3'd5;

  logic              clock = 1'b0;
  logic              reset = 1'b0;
  logic [N*MB-1:0]   req_msg = '0;
  logic [N*AW-1:0]   req_address = '0;
  logic [N*DW-1:0]   req_data = '0;
  logic [N*MB-1:0]   resp_msg;
  logic [N*AW-1:0]   resp_address;
  logic [N*DW-1:0]   resp_data;
  logic [MB-1:0]     arb2mm_msg;
  logic [AW-1:0]     arb2mm_address;
  logic [DW-1:0]     arb2mm_data;
  logic [MB-1:0]     mm2arb_msg = '0;
  logic [AW-1:0]     mm2arb_address = '0;
  logic [DW-1:0]     mm2arb_data = '0;
  logic [N-1:0]      grant;
  logic              busy;
  logic              timeout_err;

  int checks = 0;
  int failures = 0;

  mm_bypass_arbiter #(
    .NUM_REQ(N), .ADDRESS_WIDTH(AW), .DATA_WIDTH(DW), .MSG_BITS(MB),
    .NO_REQ(NO_REQ), .R_REQ(R_REQ), .WB_REQ(WB_REQ),
    .MEM_RESP(MEM_RESP), .MEM_ACK(MEM_ACK), .TIMEOUT_CYCLES(8)
  ) dut (
    .clock(clock), .reset(reset),
    .req_msg(req_msg), .req_address(req_address), .req_data(req_data),
    .resp_msg(resp_msg), .resp_address(resp_address), .resp_data(resp_data),
    .arb2mm_msg(arb2mm_msg), .arb2mm_address(arb2mm_address), .arb2mm_data(arb2mm_data),
    .mm2arb_msg(mm2arb_msg), .mm2arb_address(mm2arb_address), .mm2arb_data(mm2arb_data),
    .grant(grant), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clock = ~clock;

  initial begin
    #400000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "simulation time limit");
  end

  task automatic set_req(input int i, input logic [2:0] m, input logic [31:0] a, input logic [31:0] d);
    req_msg[i*MB +: MB]     = m;
    req_address[i*AW +: AW] = a;
    req_data[i*DW +: DW]    = d;
  endtask

  task automatic set_mm(input logic [2:0] m, input logic [31:0] a, input logic [31:0] d);
    mm2arb_msg = m; mm2arb_address = a; mm2arb_data = d;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_msg = '0; req_address = '0; req_data = '0;
    set_mm(NO_REQ, 0, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy, grant, timeout_err, arb2mm_msg} !== '0) begin
      failures++;
      $display("FAIL reset_ctrl: got busy=%b grant=%b terr=%b msg=%h expected all 0", busy, grant, timeout_err, arb2mm_msg);
    end
    checks++;
    if ({resp_msg, resp_address, resp_data, arb2mm_address, arb2mm_data} !== '0) begin
      failures++;
      $display("FAIL reset_data: got resp_msg=%h resp_addr=%h resp_data=%h expected 0", resp_msg, resp_address, resp_data);
    end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    $display("txn reset: busy=%b grant=%b", busy, grant);
  endtask

  task automatic test_single_read();
    set_req(0, R_REQ, 32'h100, 32'h0);
    @(negedge clock);
    checks++;
    if (arb2mm_msg !== R_REQ || arb2mm_address !== 32'h100 || grant !== 2'b01 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_issue: got msg=%h addr=%h grant=%b busy=%b expected 1/100/01/1", arb2mm_msg, arb2mm_address, grant, busy);
    end
    set_mm(MEM_RESP, 32'h100, 32'hDEADBEEF);
    @(negedge clock);
    set_mm(NO_REQ, 0, 0);
    checks++;
    if (resp_msg !== {3'd0, MEM_RESP} || resp_data !== {32'h0, 32'hDEADBEEF} ||
        resp_address !== {32'h0, 32'h100} || arb2mm_msg !== NO_REQ) begin
      failures++;
      $display("FAIL single_resp: got msg=%h data=%h addr=%h mm=%h expected 04/deadbeef/100/0", resp_msg, resp_data, resp_address, arb2mm_msg);
    end
    @(negedge clock);
    checks++;
    if (resp_msg !== {3'd0, MEM_RESP}) begin
      failures++;
      $display("FAIL single_hold: got msg=%h expected %h", resp_msg, {3'd0, MEM_RESP});
    end
    set_req(0, NO_REQ, 0, 0);
    @(negedge clock);
    checks++;
    if (grant !== 2'b00 || busy !== 1'b0 || resp_msg !== '0) begin
      failures++;
      $display("FAIL single_idle: got grant=%b busy=%b resp=%h expected 00/0/0", grant, busy, resp_msg);
    end
    $display("txn single_read: data=%h", 32'hDEADBEEF);
  endtask

  task automatic test_simultaneous();
    int w;
    do_reset();
    set_req(0, R_REQ, 32'h200, 0);
    set_req(1, R_REQ, 32'h300, 0);
    @(negedge clock);
    for (int t = 0; t < 4; t++) begin
      w = t % 2;
      checks++;
      if (grant !== 2'(1 << w) || arb2mm_address !== (w == 1 ? 32'h300 : 32'h200)) begin
        failures++;
        $display("FAIL simul_grant%0d: got grant=%b addr=%h expected grant=%b", t, grant, arb2mm_address, 2'(1 << w));
      end
      set_mm(MEM_RESP, arb2mm_address, 32'hA000 + t);
      @(negedge clock);
      set_mm(NO_REQ, 0, 0);
      checks++;
      if (resp_data[w*DW +: DW] !== 32'hA000 + t || resp_msg[w*MB +: MB] !== MEM_RESP) begin
        failures++;
        $display("FAIL simul_resp%0d: got data=%h msg=%h expected %h/4", t, resp_data[w*DW +: DW], resp_msg[w*MB +: MB], 32'hA000 + t);
      end
      set_req(w, NO_REQ, 0, 0);
      if (t == 3) set_req(1 - w, NO_REQ, 0, 0);
      @(negedge clock);
      checks++;
      if (grant !== 2'b00 || busy !== 1'b0) begin
        failures++;
        $display("FAIL simul_release%0d: got grant=%b busy=%b expected 00/0", t, grant, busy);
      end
      if (t < 3) set_req(w, R_REQ, (w == 1 ? 32'h300 : 32'h200), 0);
      $display("txn simultaneous %0d: winner=%0d", t, w);
      @(negedge clock);
    end
  endtask

  task automatic test_write();
    set_req(1, WB_REQ, 32'h40, 32'h12345678);
    @(negedge clock);
    checks++;
    if (grant !== 2'b10 || arb2mm_msg !== WB_REQ || arb2mm_address !== 32'h40 || arb2mm_data !== 32'h12345678) begin
      failures++;
      $display("FAIL write_issue: got grant=%b msg=%h addr=%h data=%h expected 10/2/40/12345678", grant, arb2mm_msg, arb2mm_address, arb2mm_data);
    end
    set_mm(MEM_ACK, 32'h40, 32'hFFFFFFFF);
    set_req(1, NO_REQ, 0, 0);
    @(negedge clock);
    set_mm(NO_REQ, 0, 0);
    checks++;
    if (resp_msg !== {MEM_ACK, 3'd0} || resp_data !== '0 || resp_address !== {32'h40, 32'h0}) begin
      failures++;
      $display("FAIL write_resp: got msg=%h data=%h addr=%h expected %h/0/40", resp_msg, resp_data, resp_address, {MEM_ACK, 3'd0});
    end
    @(negedge clock);
    checks++;
    if (resp_msg !== '0 || busy !== 1'b0 || grant !== 2'b00) begin
      failures++;
      $display("FAIL write_one_cycle: got resp=%h busy=%b grant=%b expected 0/0/00", resp_msg, busy, grant);
    end
    $display("txn write: addr=%h", 32'h40);
  endtask

  task automatic test_mismatch();
    set_req(0, R_REQ, 32'h100, 0);
    @(negedge clock);
    set_mm(MEM_RESP, 32'h104, 32'h1);
    @(negedge clock);
    checks++;
    if (busy !== 1'b1 || arb2mm_msg !== R_REQ || resp_msg !== '0) begin
      failures++;
      $display("FAIL mismatch_addr: got busy=%b msg=%h resp=%h expected 1/1/0", busy, arb2mm_msg, resp_msg);
    end
    set_mm(MEM_ACK, 32'h100, 32'h2);
    @(negedge clock);
    checks++;
    if (busy !== 1'b1 || arb2mm_msg !== R_REQ || resp_msg !== '0) begin
      failures++;
      $display("FAIL mismatch_code: got busy=%b msg=%h resp=%h expected 1/1/0", busy, arb2mm_msg, resp_msg);
    end
    set_mm(MEM_RESP, 32'h100, 32'hCAFEF00D);
    @(negedge clock);
    set_mm(NO_REQ, 0, 0);
    checks++;
    if (resp_msg !== {3'd0, MEM_RESP} || resp_data !== {32'h0, 32'hCAFEF00D}) begin
      failures++;
      $display("FAIL mismatch_done: got msg=%h data=%h expected 04/cafef00d", resp_msg, resp_data);
    end
    set_req(0, NO_REQ, 0, 0);
    @(negedge clock);
    $display("txn mismatch: completed busy=%b", busy);
  endtask

  task automatic test_random();
    logic [2:0]  m_msg [N];
    logic [31:0] m_addr [N];
    logic [31:0] m_data [N];
    bit          held [N];
    int          ptr, w, c, d, h;
    logic [31:0] rdata;
    logic [N*MB-1:0] e_msg;
    logic [N*AW-1:0] e_addr;
    logic [N*DW-1:0] e_data;
    do_reset();
    ptr = 0;
    for (int i = 0; i < N; i++) held[i] = 0;
    for (int r = 0; r < 60; r++) begin
      for (int i = 0; i < N; i++) begin
        if (!held[i]) begin
          c = $urandom_range(0, 9);
          m_msg[i]  = (c < 4) ? R_REQ : (c < 7) ? WB_REQ : (c == 7) ? NO_REQ : (c == 8) ? 3'd3 : 3'd7;
          m_addr[i] = $urandom & 32'hFFFF_FFFC;
          m_data[i] = $urandom;
          held[i]   = (m_msg[i] == R_REQ || m_msg[i] == WB_REQ);
        end
        set_req(i, m_msg[i], m_addr[i], m_data[i]);
      end
      @(negedge clock);
      w = -1;
      for (int k = 0; k < N; k++)
        if (w < 0 && held[(ptr + k) % N]) w = (ptr + k) % N;
      if (w < 0) begin
        checks++;
        if (busy !== 1'b0 || grant !== '0) begin
          failures++;
          $display("FAIL rand_idle%0d: got busy=%b grant=%b expected 0/0", r, busy, grant);
        end
        continue;
      end
      checks++;
      if (grant !== N'(1 << w) || arb2mm_msg !== m_msg[w] || arb2mm_address !== m_addr[w] || arb2mm_data !== m_data[w]) begin
        failures++;
        $display("FAIL rand_issue%0d: got grant=%b msg=%h addr=%h data=%h expected grant=%b msg=%h addr=%h data=%h",
                 r, grant, arb2mm_msg, arb2mm_address, arb2mm_data, N'(1 << w), m_msg[w], m_addr[w], m_data[w]);
      end
      d = $urandom_range(0, 4);
      for (int j = 0; j < d; j++) begin
        if ($urandom_range(0, 1) == 0)
          set_mm((m_msg[w] == R_REQ) ? MEM_RESP : MEM_ACK, m_addr[w] ^ 32'h4, $urandom);
        else
          set_mm((m_msg[w] == R_REQ) ? MEM_ACK : MEM_RESP, m_addr[w], $urandom);
        @(negedge clock);
        checks++;
        if (busy !== 1'b1 || arb2mm_msg !== m_msg[w] || resp_msg !== '0) begin
          failures++;
          $display("FAIL rand_wait%0d: got busy=%b msg=%h resp=%h expected 1/%h/0", r, busy, arb2mm_msg, resp_msg, m_msg[w]);
        end
      end
      rdata = $urandom;
      set_mm((m_msg[w] == R_REQ) ? MEM_RESP : MEM_ACK, m_addr[w], rdata);
      @(negedge clock);
      set_mm(NO_REQ, 0, 0);
      e_msg = '0; e_addr = '0; e_data = '0;
      e_msg[w*MB +: MB]  = (m_msg[w] == R_REQ) ? MEM_RESP : MEM_ACK;
      e_addr[w*AW +: AW] = m_addr[w];
      e_data[w*DW +: DW] = (m_msg[w] == R_REQ) ? rdata : 32'h0;
      checks++;
      if (resp_msg !== e_msg || resp_address !== e_addr || resp_data !== e_data || arb2mm_msg !== NO_REQ) begin
        failures++;
        $display("FAIL rand_resp%0d: got msg=%h addr=%h data=%h mm=%h expected msg=%h addr=%h data=%h mm=0",
                 r, resp_msg, resp_address, resp_data, arb2mm_msg, e_msg, e_addr, e_data);
      end
      h = $urandom_range(0, 2);
      repeat (h) @(negedge clock);
      checks++;
      if (resp_msg !== e_msg) begin
        failures++;
        $display("FAIL rand_hold%0d: got msg=%h expected %h", r, resp_msg, e_msg);
      end
      m_msg[w] = NO_REQ;
      held[w]  = 0;
      set_req(w, NO_REQ, m_addr[w], m_data[w]);
      @(negedge clock);
      checks++;
      if (grant !== '0 || busy !== 1'b0 || resp_msg !== '0) begin
        failures++;
        $display("FAIL rand_release%0d: got grant=%b busy=%b resp=%h expected 0/0/0", r, grant, busy, resp_msg);
      end
      ptr = (w + 1) % N;
      $display("txn random %0d: winner=%0d msg=%0d addr=%h delay=%0d", r, w, e_msg[w*MB +: MB], m_addr[w], d);
    end
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL rand_no_timeout: got %b expected 0", timeout_err);
    end
  endtask

  task automatic test_watchdog();
    do_reset();
    set_req(0, R_REQ, 32'h500, 0);
    @(negedge clock);
    repeat (7) @(negedge clock);
    checks++;
    if (timeout_err !== 1'b0) begin
      failures++;
      $display("FAIL wd_early: got %b expected 0 after 7 issue cycles", timeout_err);
    end
    @(negedge clock);
    checks++;
    if (timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL wd_fire: got %b expected 1 after 8 issue cycles", timeout_err);
    end
    repeat (5) @(negedge clock);
    checks++;
    if (busy !== 1'b1 || arb2mm_msg !== R_REQ || timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL wd_wait: got busy=%b msg=%h terr=%b expected 1/1/1", busy, arb2mm_msg, timeout_err);
    end
    set_mm(MEM_RESP, 32'h500, 32'h11);
    @(negedge clock);
    set_mm(NO_REQ, 0, 0);
    set_req(0, NO_REQ, 0, 0);
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || timeout_err !== 1'b1) begin
      failures++;
      $display("FAIL wd_sticky: got busy=%b terr=%b expected 0/1", busy, timeout_err);
    end
    $display("txn watchdog: terr=%b", timeout_err);
  endtask

  task automatic test_reset_mid();
    set_req(0, R_REQ, 32'h600, 0);
    @(negedge clock);
    checks++;
    if (grant !== 2'b01 || busy !== 1'b1) begin
      failures++;
      $display("FAIL mid_issue: got grant=%b busy=%b expected 01/1", grant, busy);
    end
    set_req(1, R_REQ, 32'h700, 0);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (arb2mm_msg !== NO_REQ || grant !== '0 || busy !== 1'b0 || timeout_err !== 1'b0 || resp_msg !== '0) begin
      failures++;
      $display("FAIL mid_async: got msg=%h grant=%b busy=%b terr=%b resp=%h expected all 0", arb2mm_msg, grant, busy, timeout_err, resp_msg);
    end
    set_req(0, NO_REQ, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (grant !== 2'b10 || arb2mm_msg !== R_REQ || arb2mm_address !== 32'h700) begin
      failures++;
      $display("FAIL mid_after: got grant=%b msg=%h addr=%h expected 10/1/700", grant, arb2mm_msg, arb2mm_address);
    end
    $display("txn reset_mid: grant=%b", grant);
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_simultaneous();
    test_write();
    test_mismatch();
    test_random();
    test_watchdog();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
